cacheline_adapter: RTL

Bridges the cache's line-wide downstream port (dfp_*) to the narrow burst memory port (bmem_*). A line read becomes one read command followed by BEATS returned beats. A line write becomes BEATS consecutive write beats. Sits between cache and the banked memory model in cpu. It replaces the direct dfp tie-off and is parametrised in bus width, line width and address width.

---
 rtl/cacheline_adapter_pkg.sv | 19 +
 rtl/cacheline_adapter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types and helpers for the cache line to burst memory adapter.
// State encodings are plain constants so older tools can consume them.
package cacheline_adapter_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] adapter_state_t;

    localparam adapter_state_t ST_IDLE       = 3'd0;
    localparam adapter_state_t ST_RD_CMD     = 3'd1;
    localparam adapter_state_t ST_RD_COLLECT = 3'd2;
    localparam adapter_state_t ST_WR_BURST   = 3'd3;
    localparam adapter_state_t ST_RESP       = 3'd4;

    function automatic int beats_of(input int line_w, input int bus_w);
        return line_w / bus_w;
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Converts line-wide cache read/write requests into a one-command read
// burst or a BEATS-long write burst on the narrow memory port.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
#(
    parameter int BUS_WIDTH  = 64,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BUS_WIDTH-1:0]  bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BUS_WIDTH-1:0]  bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS       = beats_of(LINE_WIDTH, BUS_WIDTH);
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W       = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    adapter_state_t          r_state;
    adapter_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LINE_WIDTH-1:0]   r_line;
    logic [LINE_WIDTH-1:0]   r_rdata;
    logic [CNT_W-1:0]        r_cnt;

    logic [ADDR_WIDTH-1:0]   w_addr_aligned;
    logic [LINE_WIDTH-1:0]   w_line_asm;
    logic                    w_beat_hit;
    logic                    w_wr_accept;
    logic                    w_last;

    assign w_addr_aligned = {dfp_addr[ADDR_WIDTH-1:OFFSET_BITS],
                             {OFFSET_BITS{1'b0}}};

    // Only beats tagged with our burst address belong to this line
    assign w_beat_hit  = (r_state == ST_RD_COLLECT) && bmem_rvalid
                         && (bmem_raddr == r_addr);
    assign w_wr_accept = (r_state == ST_WR_BURST) && bmem_ready;
    assign w_last      = (r_cnt == LAST_BEAT);

    always_comb begin
        w_line_asm = r_line;
        w_line_asm[r_cnt*BUS_WIDTH +: BUS_WIDTH] = bmem_rdata;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (dfp_read)
                    w_state_next = ST_RD_CMD;
                else if (dfp_write)
                    w_state_next = ST_WR_BURST;
            end
            ST_RD_CMD: begin
                if (bmem_ready)
                    w_state_next = ST_RD_COLLECT;
            end
            ST_RD_COLLECT: begin
                if (w_beat_hit && w_last)
                    w_state_next = ST_RESP;
            end
            ST_WR_BURST: begin
                if (w_wr_accept && w_last)
                    w_state_next = ST_RESP;
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_line  <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (dfp_read || dfp_write)
                        r_addr <= w_addr_aligned;
                    if (dfp_write && !dfp_read)
                        r_line <= dfp_wdata;
                end
                ST_RD_CMD: r_cnt <= '0;
                ST_RD_COLLECT: begin
                    if (w_beat_hit) begin
                        r_line <= w_line_asm;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last)
                            r_rdata <= w_line_asm;
                    end
                end
                ST_WR_BURST: begin
                    if (w_wr_accept)
                        r_cnt <= r_cnt + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bmem_read  = (r_state == ST_RD_CMD);
    assign bmem_write = (r_state == ST_WR_BURST);
    assign bmem_addr  = r_addr;
    assign bmem_wdata = bmem_write ? r_line[r_cnt*BUS_WIDTH +: BUS_WIDTH]
                                   : '0;
    assign dfp_resp   = (r_state == ST_RESP);
    assign dfp_rdata  = r_rdata;

endmodule
